// File: rtl/proc_core_param_if.sv
// Memory-side bundle for proc_core_param: instruction and data req/ready ports.
// The core is the master; shared memories or arbiters sit on the slave side.
interface proc_core_param_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic          im_req;
   logic [AW-1:0] im_addr;
   logic [15:0]   im_rdata;
   logic          im_ready;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;

   modport master (
      output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
      input  im_rdata, im_ready, dm_rdata, dm_ready
   );

   modport slave (
      input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
      output im_rdata, im_ready, dm_rdata, dm_ready
   );
endinterface

// File: rtl/proc_core_param.sv
// Parametrised multi-cycle core running the fixed 16-bit ISA.
// Fetch and data accesses use req/ready handshakes and may stall indefinitely.
module proc_core_param #(
   parameter int DW   = 16,
   parameter int AW   = 16,
   parameter int NREG = 4,
   parameter int CID  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    i_status,
   proc_core_param_if.master bus,
   output logic [AW-1:0] o_pc_out,
   output logic          o_end_process
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]    r_state;
   logic [AW-1:0] r_pc;
   logic          r_z;
   logic [15:0]   r_ir;
   logic [DW-1:0] r_regs [NREG];
   logic          r_dm_we;
   logic [AW-1:0] r_dm_addr;
   logic [DW-1:0] r_dm_wdata;

   logic [3:0]    w_op;
   logic [3:0]    w_rd;
   logic [3:0]    w_rs;
   logic [7:0]    w_imm;
   logic [DW-1:0] w_rd_val;
   logic [DW-1:0] w_rs_val;
   logic [DW-1:0] w_res;
   logic          w_wr;
   logic          w_zup;
   logic          w_jmp;
   logic          w_load_done;
   logic          w_reg_we;
   logic [DW-1:0] w_reg_wd;
   logic [2:0]    w_next;

   assign w_op  = r_ir[15:12];
   assign w_rd  = r_ir[11:8];
   assign w_rs  = r_ir[7:4];
   assign w_imm = r_ir[7:0];

   // Indices beyond NREG read as zero.
   always_comb begin
      w_rd_val = '0;
      w_rs_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (w_rd == 4'(i)) w_rd_val = r_regs[i];
         if (w_rs == 4'(i)) w_rs_val = r_regs[i];
      end
   end

   always_comb begin
      w_res = '0;
      w_wr  = 1'b0;
      w_zup = 1'b0;
      w_jmp = 1'b0;
      case (w_op)
         4'h1: begin w_res = DW'(w_imm); w_wr = 1'b1; end
         4'h2: begin w_res = w_rs_val; w_wr = 1'b1; end
         4'h3: begin
            w_res = w_rd_val + w_rs_val;
            w_wr  = 1'b1;
            w_zup = 1'b1;
         end
         4'h4: begin
            w_res = w_rd_val - w_rs_val;
            w_wr  = 1'b1;
            w_zup = 1'b1;
         end
         4'h5: begin
            w_res = w_rd_val * w_rs_val;
            w_wr  = 1'b1;
            w_zup = 1'b1;
         end
         4'h6: begin
            w_res = w_rd_val + DW'(1);
            w_wr  = 1'b1;
            w_zup = 1'b1;
         end
         4'h7: begin w_wr = 1'b1; w_zup = 1'b1; end
         4'hA: w_jmp = 1'b1;
         4'hB: w_jmp = r_z;
         4'hC: begin w_res = DW'(CID); w_wr = 1'b1; end
         default: ;
      endcase
   end

   assign w_load_done = (r_state == S_MEM) && bus.dm_ready && !r_dm_we;
   assign w_reg_we    = ((r_state == S_EXEC) && w_wr) || w_load_done;
   assign w_reg_wd    = w_load_done ? bus.dm_rdata : w_res;
   // status is only honoured on instruction boundaries.
   assign w_next      = (i_status == 2'b01) ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++)
            if (w_reg_we && w_rd == 4'(i)) r_regs[i] <= w_reg_wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_z        <= 1'b0;
         r_ir       <= '0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_status == 2'b11) begin
                  r_pc <= '0;
                  r_z  <= 1'b0;
               end else if (i_status == 2'b01) begin
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (bus.im_ready) begin
                  r_ir    <= bus.im_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_pc <= r_pc + AW'(1);
               if (w_op == 4'h8) begin
                  r_dm_we   <= 1'b0;
                  r_dm_addr <= AW'(w_rs_val);
                  r_state   <= S_MEM;
               end else if (w_op == 4'h9) begin
                  r_dm_we    <= 1'b1;
                  r_dm_addr  <= AW'(w_rd_val);
                  r_dm_wdata <= w_rs_val;
                  r_state    <= S_MEM;
               end else if (w_op == 4'hF) begin
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_zup) r_z <= (w_res == '0);
               if (w_jmp) r_pc <= AW'(w_imm);
               r_state <= w_next;
            end
            S_MEM: begin
               if (bus.dm_ready) r_state <= w_next;
            end
            S_HALT: begin
               if (i_status == 2'b11) begin
                  r_pc    <= '0;
                  r_z     <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.im_req     = (r_state == S_FETCH);
   assign bus.im_addr    = r_pc;
   assign bus.dm_req     = (r_state == S_MEM);
   assign bus.dm_we      = r_dm_we;
   assign bus.dm_addr    = r_dm_addr;
   assign bus.dm_wdata   = r_dm_wdata;
   assign o_pc_out       = r_pc;
   assign o_end_process  = (r_state == S_HALT);

endmodule
